// File: rtl/scarv_ccx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scarv_ccx_pkg : shared core-complex types and port identifiers   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package scarv_ccx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } ccx_arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/scarv_ccx_ext_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scarv_ccx_ext_arb : two-requester arbiter for the ext memory port |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module scarv_ccx_ext_arb
  import scarv_ccx_pkg::*;
#(
  parameter logic FIXED_PRIO = 1'b0,
  parameter logic PRIO_PORT  = PORT_A
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        a_req,
  input  logic        a_wen,
  input  logic [3:0]  a_strb,
  input  logic [31:0] a_wdata,
  input  logic [31:0] a_addr,
  output logic        a_gnt,
  output logic        a_error,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_wen,
  input  logic [3:0]  b_strb,
  input  logic [31:0] b_wdata,
  input  logic [31:0] b_addr,
  output logic        b_gnt,
  output logic        b_error,
  output logic [31:0] b_rdata,
  output logic        ext_req,
  output logic        ext_wen,
  output logic [3:0]  ext_strb,
  output logic [31:0] ext_wdata,
  output logic [31:0] ext_addr,
  input  logic        ext_gnt,
  input  logic        ext_error,
  input  logic [31:0] ext_rdata
);

  ccx_arb_state_t state_q;
  logic           last_sel_q;
  logic           rsp_pend_q;
  logic           rsp_sel_q;

  logic           sel;
  logic           sel_req;
  logic           accept;

  // A lock pins the selection so a stalled request cannot be re-arbitrated.
  always_comb begin
    sel = PORT_A;
    case (state_q)
      LOCK_A:  sel = PORT_A;
      LOCK_B:  sel = PORT_B;
      default: begin
        if (a_req && b_req) sel = FIXED_PRIO ? PRIO_PORT : ~last_sel_q;
        else if (b_req)     sel = PORT_B;
        else                sel = PORT_A;
      end
    endcase
  end

  assign sel_req   = (sel == PORT_B) ? b_req : a_req;
  assign accept    = sel_req & ext_gnt & ~g_reset;

  assign ext_req   = sel_req & ~g_reset;
  assign ext_wen   = (sel == PORT_B) ? b_wen   : a_wen;
  assign ext_strb  = (sel == PORT_B) ? b_strb  : a_strb;
  assign ext_wdata = (sel == PORT_B) ? b_wdata : a_wdata;
  assign ext_addr  = (sel == PORT_B) ? b_addr  : a_addr;

  assign a_gnt     = accept & (sel == PORT_A);
  assign b_gnt     = accept & (sel == PORT_B);

  assign a_rdata   = ext_rdata;
  assign b_rdata   = ext_rdata;
  assign a_error   = ext_error & rsp_pend_q & (rsp_sel_q == PORT_A) & ~g_reset;
  assign b_error   = ext_error & rsp_pend_q & (rsp_sel_q == PORT_B) & ~g_reset;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q    <= IDLE;
      last_sel_q <= PORT_B;
      rsp_pend_q <= 1'b0;
      rsp_sel_q  <= PORT_A;
    end else begin
      rsp_pend_q <= accept;
      if (accept) begin
        last_sel_q <= sel;
        rsp_sel_q  <= sel;
      end
      case (state_q)
        IDLE: begin
          if (sel_req && !ext_gnt) state_q <= (sel == PORT_B) ? LOCK_B : LOCK_A;
        end
        LOCK_A, LOCK_B: begin
          if (sel_req && ext_gnt) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Dropping req while locked breaks the memif protocol.
  a_lock_a_holds_req: assert property (@(posedge g_clk) disable iff (g_reset)
    (state_q == LOCK_A) |-> a_req);
  a_lock_b_holds_req: assert property (@(posedge g_clk) disable iff (g_reset)
    (state_q == LOCK_B) |-> b_req);
`endif

endmodule
`default_nettype wire

// File: tb/tb_scarv_ccx_ext_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_scarv_ccx_ext_arb : directed bench for the ext memory arbiter  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_scarv_ccx_ext_arb;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        a_req, a_wen, b_req, b_wen, ext_gnt, ext_error;
  logic [3:0]  a_strb, b_strb;
  logic [31:0] a_wdata, a_addr, b_wdata, b_addr, ext_rdata;

  logic        a_gnt, a_error, b_gnt, b_error, ext_req, ext_wen;
  logic [31:0] a_rdata, b_rdata, ext_wdata, ext_addr;
  logic [3:0]  ext_strb;

  logic        fp_a_gnt, fp_a_error, fp_b_gnt, fp_b_error, fp_ext_req, fp_ext_wen;
  logic [31:0] fp_a_rdata, fp_b_rdata, fp_ext_wdata, fp_ext_addr;
  logic [3:0]  fp_ext_strb;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] ADDR_A = 32'hA000_0010;
  localparam logic [31:0] ADDR_B = 32'hB000_0020;

  always #5 g_clk = ~g_clk;

  scarv_ccx_ext_arb #(.FIXED_PRIO(1'b0), .PRIO_PORT(1'b0)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .a_req(a_req), .a_wen(a_wen), .a_strb(a_strb), .a_wdata(a_wdata), .a_addr(a_addr),
    .a_gnt(a_gnt), .a_error(a_error), .a_rdata(a_rdata),
    .b_req(b_req), .b_wen(b_wen), .b_strb(b_strb), .b_wdata(b_wdata), .b_addr(b_addr),
    .b_gnt(b_gnt), .b_error(b_error), .b_rdata(b_rdata),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_strb(ext_strb), .ext_wdata(ext_wdata),
    .ext_addr(ext_addr), .ext_gnt(ext_gnt), .ext_error(ext_error), .ext_rdata(ext_rdata)
  );

  // Fixed-priority instance; its external side never stalls.
  scarv_ccx_ext_arb #(.FIXED_PRIO(1'b1), .PRIO_PORT(1'b1)) dut_fp (
    .g_clk(g_clk), .g_reset(g_reset),
    .a_req(a_req), .a_wen(a_wen), .a_strb(a_strb), .a_wdata(a_wdata), .a_addr(a_addr),
    .a_gnt(fp_a_gnt), .a_error(fp_a_error), .a_rdata(fp_a_rdata),
    .b_req(b_req), .b_wen(b_wen), .b_strb(b_strb), .b_wdata(b_wdata), .b_addr(b_addr),
    .b_gnt(fp_b_gnt), .b_error(fp_b_error), .b_rdata(fp_b_rdata),
    .ext_req(fp_ext_req), .ext_wen(fp_ext_wen), .ext_strb(fp_ext_strb),
    .ext_wdata(fp_ext_wdata), .ext_addr(fp_ext_addr),
    .ext_gnt(1'b1), .ext_error(ext_error), .ext_rdata(ext_rdata)
  );

  task automatic idle_inputs;
    a_req = 1'b0; b_req = 1'b0; ext_gnt = 1'b0; ext_error = 1'b0;
  endtask

  task automatic pulse_reset;
    @(negedge g_clk);
    g_reset = 1'b1;
    #2 g_reset = 1'b0;
  endtask

  task automatic test_reset;
    a_wen = 1'b0; a_strb = 4'h3; a_wdata = 32'h1111_1111; a_addr = ADDR_A;
    b_wen = 1'b1; b_strb = 4'hF; b_wdata = 32'h2222_2222; b_addr = ADDR_B;
    a_req = 1'b1; b_req = 1'b1; ext_gnt = 1'b1; ext_error = 1'b1; ext_rdata = 32'h0;
    #2;
    n_tests++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL rst_ext_req got %b exp 0", ext_req); end
    n_tests++; if (a_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_a_gnt got %b exp 0", a_gnt); end
    n_tests++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_b_gnt got %b exp 0", b_gnt); end
    n_tests++; if ({a_error, b_error} !== 2'b00) begin n_fail++; $display("FAIL rst_errors got %b exp 00", {a_error, b_error}); end
    @(negedge g_clk);
    idle_inputs();
    g_reset = 1'b0;
    #2;
    n_tests++; if ({ext_req, a_gnt, b_gnt} !== 3'b000) begin n_fail++; $display("FAIL idle_outputs got %b exp 000", {ext_req, a_gnt, b_gnt}); end
  endtask

  task automatic test_single_a;
    @(negedge g_clk);
    a_req = 1'b1; a_addr = 32'h1000_0004; ext_gnt = 1'b1;
    #2;
    n_tests++; if ({a_gnt, b_gnt} !== 2'b10) begin n_fail++; $display("FAIL t1_gnt got %b exp 10", {a_gnt, b_gnt}); end
    n_tests++; if (ext_addr !== 32'h1000_0004) begin n_fail++; $display("FAIL t1_ext_addr got %h exp 10000004", ext_addr); end
    @(negedge g_clk);
    a_req = 1'b0; ext_gnt = 1'b0; ext_rdata = 32'hDEAD_BEEF; ext_error = 1'b0;
    #2;
    n_tests++; if (a_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t1_a_rdata got %h exp deadbeef", a_rdata); end
    n_tests++; if (a_error !== 1'b0) begin n_fail++; $display("FAIL t1_a_error got %b exp 0", a_error); end
    @(negedge g_clk);
    ext_error = 1'b1;
    #2;
    n_tests++; if ({a_error, b_error} !== 2'b00) begin n_fail++; $display("FAIL t1_no_pending_err got %b exp 00", {a_error, b_error}); end
    ext_error = 1'b0;
    a_addr = ADDR_A;
  endtask

  task automatic test_round_robin;
    logic exp_b, exp_aerr, exp_berr;
    pulse_reset();
    ext_error = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge g_clk);
      a_req = 1'b1; b_req = 1'b1; ext_gnt = 1'b1;
      #2;
      exp_b    = (k % 2) == 1;
      exp_aerr = (k > 0) && ((k % 2) == 1);
      exp_berr = (k > 0) && ((k % 2) == 0);
      n_tests++; if ({a_gnt, b_gnt} !== {~exp_b, exp_b}) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, {a_gnt, b_gnt}, {~exp_b, exp_b}); end
      n_tests++; if (ext_addr !== (exp_b ? ADDR_B : ADDR_A) || ext_wen !== exp_b) begin n_fail++; $display("FAIL rr_payload[%0d] got %h/%b", k, ext_addr, ext_wen); end
      n_tests++; if ({a_error, b_error} !== {exp_aerr, exp_berr}) begin n_fail++; $display("FAIL rr_err[%0d] got %b exp %b", k, {a_error, b_error}, {exp_aerr, exp_berr}); end
    end
    @(negedge g_clk);
    a_req = 1'b0; b_req = 1'b0; ext_gnt = 1'b0;
    #2;
    n_tests++; if ({a_error, b_error} !== 2'b01) begin n_fail++; $display("FAIL rr_last_err got %b exp 01", {a_error, b_error}); end
    ext_error = 1'b0;
  endtask

  task automatic test_stall;
    @(negedge g_clk);
    a_req = 1'b1; ext_gnt = 1'b1;
    #2;
    n_tests++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL st_pre_a_gnt got %b exp 1", a_gnt); end
    for (int k = 0; k < 4; k++) begin
      @(negedge g_clk);
      a_req = 1'b1; b_req = (k > 0); ext_gnt = (k == 3);
      #2;
      n_tests++; if (ext_req !== 1'b1 || ext_addr !== ADDR_A) begin n_fail++; $display("FAIL st_hold[%0d] got %b/%h exp 1/%h", k, ext_req, ext_addr, ADDR_A); end
      n_tests++; if ({a_gnt, b_gnt} !== {(k == 3), 1'b0}) begin n_fail++; $display("FAIL st_gnt[%0d] got %b exp %b", k, {a_gnt, b_gnt}, {(k == 3), 1'b0}); end
    end
    @(negedge g_clk);
    a_req = 1'b0; b_req = 1'b1; ext_gnt = 1'b1;
    #2;
    n_tests++; if ({a_gnt, b_gnt} !== 2'b01 || ext_addr !== ADDR_B) begin n_fail++; $display("FAIL st_then_b got %b/%h exp 01/%h", {a_gnt, b_gnt}, ext_addr, ADDR_B); end
    @(negedge g_clk);
    idle_inputs();
  endtask

  task automatic test_fixed_prio;
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge g_clk);
      a_req = 1'b1; b_req = 1'b1; ext_gnt = 1'b1;
      #2;
      n_tests++; if ({fp_a_gnt, fp_b_gnt} !== 2'b01 || fp_ext_addr !== ADDR_B) begin n_fail++; $display("FAIL fp_b_wins[%0d] got %b/%h exp 01/%h", k, {fp_a_gnt, fp_b_gnt}, fp_ext_addr, ADDR_B); end
    end
    @(negedge g_clk);
    b_req = 1'b0;
    #2;
    n_tests++; if ({fp_a_gnt, fp_b_gnt} !== 2'b10) begin n_fail++; $display("FAIL fp_a_after got %b exp 10", {fp_a_gnt, fp_b_gnt}); end
    @(negedge g_clk);
    idle_inputs();
  endtask

  task automatic test_b_error;
    @(negedge g_clk);
    b_req = 1'b1; ext_gnt = 1'b1;
    #2;
    n_tests++; if ({a_gnt, b_gnt} !== 2'b01) begin n_fail++; $display("FAIL be_gnt got %b exp 01", {a_gnt, b_gnt}); end
    @(negedge g_clk);
    b_req = 1'b0; ext_gnt = 1'b0; ext_error = 1'b1; ext_rdata = 32'h1234_5678;
    #2;
    n_tests++; if ({a_error, b_error} !== 2'b01) begin n_fail++; $display("FAIL be_err got %b exp 01", {a_error, b_error}); end
    n_tests++; if (b_rdata !== 32'h1234_5678 || a_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL be_rdata got %h/%h exp 12345678", a_rdata, b_rdata); end
    ext_error = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge g_clk);
    a_req = 1'b1; b_req = 1'b0; ext_gnt = 1'b1;
    @(negedge g_clk);
    ext_gnt = 1'b0; ext_error = 1'b1;
    #1;
    n_tests++; if (a_error !== 1'b1) begin n_fail++; $display("FAIL rm_pending_err got %b exp 1", a_error); end
    g_reset = 1'b1;
    #1;
    n_tests++; if ({a_error, ext_req} !== 2'b00) begin n_fail++; $display("FAIL rm_err_dropped got %b exp 00", {a_error, ext_req}); end
    @(negedge g_clk);
    g_reset = 1'b0; ext_error = 1'b0; ext_gnt = 1'b1;
    #2;
    n_tests++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_after_rel got %b exp 1", a_gnt); end
    @(negedge g_clk);
    ext_gnt = 1'b0;
    @(negedge g_clk);
    b_req = 1'b1;
    #1;
    n_tests++; if (ext_req !== 1'b1 || ext_addr !== ADDR_A) begin n_fail++; $display("FAIL rm_locked got %b/%h exp 1/%h", ext_req, ext_addr, ADDR_A); end
    g_reset = 1'b1; ext_gnt = 1'b1; ext_error = 1'b1;
    #1;
    n_tests++; if ({ext_req, a_gnt, b_gnt, a_error, b_error} !== 5'b0) begin n_fail++; $display("FAIL rm_forced got %b exp 00000", {ext_req, a_gnt, b_gnt, a_error, b_error}); end
    @(negedge g_clk);
    g_reset = 1'b0; ext_error = 1'b0;
    #2;
    n_tests++; if ({a_gnt, b_gnt} !== 2'b10) begin n_fail++; $display("FAIL rm_first_conflict got %b exp 10", {a_gnt, b_gnt}); end
    @(negedge g_clk);
    #2;
    n_tests++; if ({a_gnt, b_gnt} !== 2'b01) begin n_fail++; $display("FAIL rm_second_conflict got %b exp 01", {a_gnt, b_gnt}); end
    @(negedge g_clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_stall();
    test_fixed_prio();
    test_b_error();
    test_reset_mid();
    repeat (2) @(negedge g_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d tests", n_tests);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/scarv_ccx_ext_arb.md
Name: scarv_ccx_ext_arb

Overview:
Two-requester arbiter that shares the single external memory port between two memif requesters (A: instruction side, B: data side) inside the core complex.
- Sits between the interconnect's external-region outputs and the top-level external memory port.
- Selects one requester per transaction, round-robin or fixed priority.
- Holds the selection stable while the external side stalls.
- Routes each response back to the requester that issued it.

Parameters:
FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = fixed priority.
PRIO_PORT, 0, port that wins conflicts when FIXED_PRIO=1 (0 = A, 1 = B).

Ports:
g_clk  in  1  clock; all state on rising edge.
g_reset  in  1  asynchronous, active-high reset.
a_req  in  1  requester A request.
a_wen  in  1  A write enable.
a_strb  in  4  A write byte strobe.
a_wdata  in  32  A write data.
a_addr  in  32  A address.
a_gnt  out  1  A request accepted this cycle.
a_error  out  1  A response error.
a_rdata  out  32  A read data.
b_req, b_wen, b_strb, b_wdata, b_addr, b_gnt, b_error, b_rdata  (same as A)  requester B.
ext_req  out  1  external request.
ext_wen  out  1  external write enable.
ext_strb  out  4  external strobe.
ext_wdata  out  32  external write data.
ext_addr  out  32  external address.
ext_gnt  in  1  external accepted request.
ext_error  in  1  external response error.
ext_rdata  in  32  external read data.

Behaviour:
Protocol:
- A request is accepted in the cycle where req and gnt are both high.
- The response (rdata, error) is valid exactly one cycle after acceptance.
- A requester holds req and all payload stable until it is granted.

State:
- FSM states: IDLE, LOCK_A, LOCK_B.
- last_sel: 1 bit, the port granted most recently.
- rsp_pend: 1 bit, a response is due this cycle.
- rsp_sel: 1 bit, the port that owns the pending response.

Reset:
- State goes to IDLE, last_sel = B (so A wins the first conflict), rsp_pend = 0, rsp_sel = A.
- While g_reset is high: ext_req, a_gnt, b_gnt, a_error, b_error are all forced to 0.

Selection (combinational, port sel):
- IDLE, only one req high: sel = that port.
- IDLE, both high, round-robin: sel = port != last_sel.
- IDLE, both high, FIXED_PRIO=1: sel = PRIO_PORT.
- IDLE, neither high: ext_req = 0, both gnt = 0.
- LOCK_A: sel = A regardless of b_req. LOCK_B: sel = B regardless of a_req.

Outputs:
- ext_req = sel.req; ext_wen/strb/wdata/addr are muxed from sel.
- sel.gnt = ext_gnt; the unselected port's gnt = 0.
- Zero added latency: the grant passes through in the same cycle.

Transitions:
- IDLE: sel.req & ext_gnt stays in IDLE; sel.req & !ext_gnt goes to LOCK_sel.
- LOCK_x: ext_gnt returns to IDLE; otherwise stays in LOCK_x.
- On every acceptance: last_sel <= sel, rsp_pend <= 1, rsp_sel <= sel.
- With no acceptance: rsp_pend <= 0.
- Back-to-back acceptances are allowed. A new grant may coincide with the previous response cycle; rsp_* is updated every cycle.

Response routing:
- a_rdata = b_rdata = ext_rdata (broadcast).
- a_error = ext_error & rsp_pend & (rsp_sel == A); b_error likewise for B.

Boundary conditions:
- Requester drops req while locked: this is a protocol violation. The FSM stays locked with ext_req low, and a simulation assertion fires.
- Async reset mid-lock or with a response pending: the response is dropped and no error is delivered.

Decomposition:
- Shared package scarv_ccx_pkg holds typedef ccx_arb_state_t {IDLE, LOCK_A, LOCK_B} and localparams PORT_A = 1'b0, PORT_B = 1'b1.
- No sub-module; request muxing is inline.

Test Plan:
1. Reset, then a_req=1 addr=0x1000_0004, ext_gnt=1 -> a_gnt=1 same cycle, ext_addr=0x1000_0004; next cycle ext_rdata=0xDEADBEEF appears on a_rdata and a_error=0.
2. a_req and b_req both held, ext_gnt=1 constant, FIXED_PRIO=0 -> grant order A,B,A,B over 4 cycles, with the matching ext_addr each cycle.
3. Both req, ext_gnt=0 for 3 cycles, then 1 -> ext_addr stays on A's address for all 4 cycles, b_gnt=0 throughout, a_gnt=1 on cycle 4; next cycle B is granted.
4. FIXED_PRIO=1, PRIO_PORT=1, both req, ext_gnt=1 -> b_gnt=1 every cycle, a_gnt=0 until b_req drops.
5. B granted with ext_error=1 in the following cycle -> b_error=1 and a_error=0 in that cycle.
6. g_reset asserted while in LOCK_A with rsp_pend=1 -> ext_req, a_gnt, b_gnt, a_error and b_error go to 0 immediately (asynchronously); after release, the state is IDLE and the first conflict goes to A.
